// File: rtl/cneg_pkg.sv
// rtl/cneg_pkg.sv - shared mode and FSM state encodings for the chunked conditional negator
package cneg_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_ONES = 2'd1,
        MODE_TWOS = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/cond_negate_seq_if.sv
// rtl/cond_negate_seq_if.sv - operand/result handshake bundle for cond_negate_seq
interface cond_negate_seq_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             overflow;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, overflow
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, overflow
    );

endinterface

// File: rtl/cneg_chunk.sv
// rtl/cneg_chunk.sv - one CHUNK-bit slice of conditional invert plus carry-in
module cneg_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] chunk,
    input  logic             inv,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] full;

    assign full = {1'b0, chunk ^ {CHUNK{inv}}} + {{CHUNK{1'b0}}, cin};
    assign sum  = full[CHUNK-1:0];
    assign cout = full[CHUNK];

endmodule

// File: rtl/cond_negate_seq.sv
// rtl/cond_negate_seq.sv - multi-cycle pass/ones'/two's-complement negator, CHUNK bits per cycle
module cond_negate_seq
    import cneg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic            clock,
    input logic            reset,
    cond_negate_seq_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q;
    state_e           state_d;
    logic             accept;
    logic             step;

    logic [WIDTH-1:0] op_q;
    logic [WIDTH-1:0] res_q;
    logic             inv_q;
    logic             carry_q;
    logic             ovf_q;
    logic [IDXW-1:0]  idx_q;

    mode_e            mode_in;
    logic [CHUNK-1:0] op_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;

    assign mode_in = mode_e'(bus.mode);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        step         = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A single shared slice adder walks the operand; the carry register links consecutive chunks.
    assign op_chunk = op_q[int'(idx_q)*CHUNK +: CHUNK];

    cneg_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .chunk (op_chunk),
        .inv   (inv_q),
        .cin   (carry_q),
        .sum   (chunk_sum),
        .cout  (chunk_cout)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q    <= '0;
            res_q   <= '0;
            inv_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            op_q    <= bus.in_data;
            inv_q   <= (mode_in == MODE_ONES) || (mode_in == MODE_TWOS);
            carry_q <= (mode_in == MODE_TWOS);
            ovf_q   <= (mode_in == MODE_TWOS) && (bus.in_data == MOST_NEG);
            idx_q   <= '0;
        end else if (step) begin
            res_q[int'(idx_q)*CHUNK +: CHUNK] <= chunk_sum;
            carry_q <= chunk_cout;
            idx_q   <= (idx_q == LAST_IDX) ? '0 : idx_q + IDXW'(1);
        end
    end

    assign bus.out_data = res_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_cond_negate_seq.sv
// tb/tb_cond_negate_seq.sv - directed and chunk-sweep checks for cond_negate_seq
module tb_cond_negate_seq;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit sweep_go = 1'b0;
    int sw_finished = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    cond_negate_seq_if #(.WIDTH(32)) b0 ();
    cond_negate_seq #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (b0)
    );

    typedef struct {
        logic [31:0] d;
        logic [1:0]  m;
        logic [31:0] e;
        logic        o;
    } vec_t;

    vec_t vecs [7] = '{
        '{32'h00000001, 2'd2, 32'hFFFFFFFF, 1'b0},
        '{32'h0F0F00FF, 2'd1, 32'hF0F0FF00, 1'b0},
        '{32'h12345678, 2'd0, 32'h12345678, 1'b0},
        '{32'hDEADBEEF, 2'd3, 32'hDEADBEEF, 1'b0},
        '{32'h80000000, 2'd2, 32'h80000000, 1'b1},
        '{32'h00000000, 2'd2, 32'h00000000, 1'b0},
        '{32'h000000FF, 2'd2, 32'hFFFFFF01, 1'b0}
    };

    task automatic wait_ready0(input string tag);
        for (int i = 0; i < 20 && !b0.in_ready; i++) @(negedge clock);
        check({tag, " ready"}, b0.in_ready, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [31:0] d, input logic [1:0] m,
                          input logic [31:0] e, input logic o);
        int lat;
        @(negedge clock);
        b0.in_valid  = 1'b1;
        b0.in_data   = d;
        b0.mode      = m;
        b0.out_ready = 1'b1;
        wait_ready0(tag);
        @(posedge clock);
        #1;
        b0.in_valid = 1'b0;
        b0.in_data  = ~d;
        b0.mode     = ~m;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            lat++;
            if (b0.out_valid) break;
        end
        check({tag, " latency"}, lat, 5);
        check({tag, " data"}, b0.out_data, e);
        check({tag, " ovf"}, b0.overflow, o);
        @(negedge clock);
        check({tag, " valid drop"}, b0.out_valid, 1'b0);
    endtask

    initial begin
        logic [31:0] bp_data;
        b0.in_valid  = 1'b0;
        b0.in_data   = '0;
        b0.mode      = '0;
        b0.out_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("rst in_ready", b0.in_ready, 1'b1);
        check("rst out_valid", b0.out_valid, 1'b0);
        check("rst out_data", b0.out_data, 32'h0);
        check("rst overflow", b0.overflow, 1'b0);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_op($sformatf("vec%0d", v), vecs[v].d, vecs[v].m, vecs[v].e, vecs[v].o);
        end

        // Backpressure: result held while downstream stalls, upstream noise ignored.
        @(negedge clock);
        b0.in_valid  = 1'b1;
        b0.in_data   = 32'h80000000;
        b0.mode      = 2'd2;
        b0.out_ready = 1'b0;
        wait_ready0("bp");
        @(posedge clock);
        #1;
        b0.in_valid = 1'b0;
        for (int i = 0; i < 40 && !b0.out_valid; i++) @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp%0d valid", i), b0.out_valid, 1'b1);
            check($sformatf("bp%0d data", i), b0.out_data, 32'h80000000);
            check($sformatf("bp%0d ovf", i), b0.overflow, 1'b1);
            check($sformatf("bp%0d in_ready", i), b0.in_ready, 1'b0);
            bp_data     = 32'h11111111 * (i + 1);
            b0.in_valid = 1'b1;
            b0.in_data  = bp_data;
            b0.mode     = 2'(i + 1);
            if (i < 3) @(negedge clock);
        end
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("bp release in_ready", b0.in_ready, 1'b1);
        check("bp release valid", b0.out_valid, 1'b0);
        check("bp no capture", b0.out_data, 32'h80000000);

        // Reset in the second RUN cycle discards the operation.
        b0.in_valid = 1'b1;
        b0.in_data  = 32'h00000005;
        b0.mode     = 2'd2;
        wait_ready0("rst op");
        @(posedge clock);
        #1;
        b0.in_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid rst in_ready", b0.in_ready, 1'b1);
        check("mid rst out_valid", b0.out_valid, 1'b0);
        check("mid rst out_data", b0.out_data, 32'h0);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check("mid rst no output", b0.out_valid, 1'b0);
        end
        run_op("post rst ones", 32'h00000000, 2'd1, 32'hFFFFFFFF, 1'b0);

        sweep_go = 1'b1;
        for (int i = 0; i < 90000 && sw_finished < 3; i++) @(negedge clock);
        check("sweep complete", sw_finished, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    localparam int SW_CHUNK [3] = '{1, 4, 32};

    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int CH = SW_CHUNK[g];
        localparam int NC = 32 / CH;

        cond_negate_seq_if #(.WIDTH(32)) bus ();
        cond_negate_seq #(.WIDTH(32), .CHUNK(CH)) dut (
            .clock (clock),
            .reset (reset),
            .bus   (bus)
        );

        initial begin
            logic [31:0] d;
            logic [31:0] e;
            logic [1:0]  m;
            logic        o;
            int          lat;
            bus.in_valid  = 1'b0;
            bus.in_data   = '0;
            bus.mode      = '0;
            bus.out_ready = 1'b1;
            wait (sweep_go);
            for (int k = 0; k < 1000; k++) begin
                d = $urandom;
                m = 2'($urandom_range(0, 3));
                if (k % 50 == 0) begin
                    d = 32'h80000000;
                    m = 2'd2;
                end else if (k % 50 == 1) begin
                    d = 32'h0;
                    m = 2'd2;
                end
                case (m)
                    2'd1:    e = ~d;
                    2'd2:    e = 32'd0 - d;
                    default: e = d;
                endcase
                o = (m == 2'd2) && (d == 32'h80000000);

                @(negedge clock);
                bus.in_valid = 1'b1;
                bus.in_data  = d;
                bus.mode     = m;
                for (int i = 0; i < 40 && !bus.in_ready; i++) @(negedge clock);
                @(posedge clock);
                #1;
                bus.in_valid = 1'b0;
                bus.in_data  = ~d;
                lat = 0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clock);
                    lat++;
                    if (bus.out_valid) break;
                end
                check($sformatf("sw c%0d op%0d latency", CH, k), lat, NC + 1);
                check($sformatf("sw c%0d op%0d data d=%h m=%0d", CH, k, d, m), bus.out_data, e);
                check($sformatf("sw c%0d op%0d ovf", CH, k), bus.overflow, o);
            end
            sw_finished++;
        end
    end

endmodule
